seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the team's BCD-to-seven-segment driver.
- Monitors a time-multiplexed, active-low seven-segment display bus: shared segment lines plus one-hot active-low digit enables.
- Recovers the BCD value shown on each digit and delivers complete display frames over a valid/ready handshake.
- Used as a self-check and readback monitor beside the display driver, and to capture displays from external boards.

Parameters:
- NDIG, 4: number of multiplexed digits (2..8).
- STABLE_CYC, 4: consecutive identical synchronized samples required before a digit is captured (2..255).

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- seg_n, input, 7: segments {a,b,c,d,e,f,g}, a = bit 6, active low; asynchronous to clk.
- dig_n, input, NDIG: digit enables, active low, bit i = digit i; asynchronous to clk.
- frame_valid, output, 1: frame_bcd/frame_err hold a complete frame.
- frame_ready, input, 1: consumer accepts the frame.
- frame_bcd, output, 4*NDIG: digit i code at [4i+3:4i]; 0-9 = digit value, 4'hF = blank, 4'hE = invalid glyph.
- frame_err, output, NDIG: bit i set when digit i captured an invalid glyph.
- overrun, output, 1: sticky; a completed frame was dropped.
- clr_overrun, input, 1: clears overrun.

Behaviour:
- Reset (reset_n = 0 at an edge) clears:
  - frame_valid = 0, frame_bcd = 0, frame_err = 0, overrun = 0;
  - synchronizers = all ones, stability counter = 0, capture mask = 0, digit stores = 4'hF.
- Reset asserted mid-operation discards any partial or pending frame; there is no output on the cycle after reset.
- Input path: seg_n and dig_n pass through a 2-flop synchronizer. s2 is the synchronized value.
- Stability counter:
  - Loads 1 when {s2_seg, s2_dig} differs from its value on the previous edge.
  - Otherwise increments, saturating at STABLE_CYC.
- Capture conditions, evaluated on the first edge after the counter reaches STABLE_CYC. All of the following must hold:
  - s2_dig has exactly one bit low;
  - that digit has not already been captured in the current activation.
- Capture latency: a new input value first sampled at edge k is captured at edge k+STABLE_CYC+1.
- Each digit is captured once per activation. The per-activation flag clears when s2_dig changes.
- A later activation of the same digit before frame completion overwrites its store with the latest glyph.
- No capture occurs when s2_dig is all ones or has more than one bit low. The counter keeps running in that case.
- Glyph map (active-low abcdefg to code):
  - 0000001 -> 0; 1001111 -> 1; 0010010 -> 2; 0000110 -> 3; 1001100 -> 4;
  - 0100100 -> 5; 0100000 -> 6; 0001111 -> 7; 0000000 -> 8; 0001100 -> 9;
  - 1111111 -> F (blank, not an error);
  - any other pattern -> E with its err bit set.
- Frame assembly:
  - Capture mask bit i sets on capture of digit i.
  - When the mask is all ones, at the next edge the digit stores and err bits are loaded to the outputs, frame_valid = 1, and the mask clears.
- Handshake:
  - Transfer occurs on an edge with frame_valid & frame_ready. frame_valid falls at that edge.
  - If a new frame completes on the same edge as a transfer, the new frame loads and frame_valid stays 1 (back-to-back).
  - Outputs are stable while frame_valid & !frame_ready.
- Overrun:
  - A frame completing while frame_valid & !frame_ready is discarded, and its mask is cleared.
  - overrun = 1 on that edge. Pending outputs are unchanged.
  - clr_overrun clears overrun on the next edge. A simultaneous new overrun wins, leaving overrun = 1.

Optional Feature:
- Macro: SEG7_SCAN_ALT_GLYPH_EN.
- Defined: these alternate glyphs are also accepted without error:
  - 1100000 -> 6 (no top segment);
  - 0000100 -> 9 (with bottom segment);
  - 0001101 -> 7 (with segment f).
- Undefined: those three patterns decode to E with the err bit set.

Test Plan:
- Reset then idle: reset_n = 0 for 2 cycles, then dig_n = all ones for 100 cycles -> frame_valid stays 0, frame_bcd = 0, overrun = 0.
- Clean scan, frame_ready = 1, each digit held 10 cycles, STABLE_CYC = 4:
  - digit0 = 0000110, digit1 = 0001111, digit2 = 1111111, digit3 = 0010010;
  - expect frame_bcd = 16'h2F73, frame_err = 0, one frame_valid pulse per full scan.
- Invalid glyph: digit3 = 1010101, others as above -> frame_bcd[15:12] = 4'hE, frame_err = 4'b1000.
- Glitch rejection:
  - digit1 pattern held only 3 cycles, then digit1 = 1001111 for 10 cycles -> digit1 code = 1.
  - Two digits enabled simultaneously -> no capture.
- Backpressure: frame_ready = 0 across two full scans:
  - first frame held stable, overrun = 1 after the second completes;
  - then frame_ready = 1 for 1 cycle and clr_overrun pulse -> frame_valid = 0, overrun = 0.
- Latency and reset mid-scan:
  - Stable digit0 first sampled at edge k -> capture at edge k+5.
  - reset_n = 0 after 3 digits captured -> next frame requires all 4 digits again.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Frame delivery channel for seg7_scan_decoder: valid/ready handshake carrying
// decoded BCD digits (4 bits per digit) and per-digit invalid-glyph flags.
interface seg7_scan_decoder_if #(
    parameter int unsigned NDIG = 4
);
    logic                frame_valid;
    logic                frame_ready;
    logic [4*NDIG-1:0]   frame_bcd;
    logic [NDIG-1:0]     frame_err;

    modport master (
        output frame_valid,
        output frame_bcd,
        output frame_err,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_bcd,
        input  frame_err,
        output frame_ready
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment bus and recovers whole display frames as BCD.
// Optional macro SEG7_SCAN_ALT_GLYPH_EN accepts alternate 6/7/9 glyph shapes as valid digits.
module seg7_scan_decoder #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           seg_n,
    input  logic [NDIG-1:0]      dig_n,
    seg7_scan_decoder_if.master  frm,
    output logic                 overrun,
    input  logic                 clr_overrun
);
    localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
    localparam int unsigned BCD_W = 4 * NDIG;

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYC);
    localparam logic [3:0]       CODE_BLANK = 4'hF;
    localparam logic [3:0]       CODE_ERR   = 4'hE;

    // Two-flop synchronizers; both bus inputs are asynchronous to clk.
    logic [6:0]      r_seg_s1;
    logic [6:0]      r_seg_s2;
    logic [NDIG-1:0] r_dig_s1;
    logic [NDIG-1:0] r_dig_s2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
            r_dig_s1 <= '1;
            r_dig_s2 <= '1;
        end else begin
            r_seg_s1 <= seg_n;
            r_seg_s2 <= r_seg_s1;
            r_dig_s1 <= dig_n;
            r_dig_s2 <= r_dig_s1;
        end
    end

    // s2 is about to take a new value on this edge when s1 differs from it.
    logic w_bus_change;
    logic w_dig_change;

    assign w_bus_change = (r_seg_s1 != r_seg_s2) || (r_dig_s1 != r_dig_s2);
    assign w_dig_change = (r_dig_s1 != r_dig_s2);

    // Counts edges for which s2 has held its current value, saturating.
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_bus_change) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b0000001: res = {1'b0, 4'd0};
            7'b1001111: res = {1'b0, 4'd1};
            7'b0010010: res = {1'b0, 4'd2};
            7'b0000110: res = {1'b0, 4'd3};
            7'b1001100: res = {1'b0, 4'd4};
            7'b0100100: res = {1'b0, 4'd5};
            7'b0100000: res = {1'b0, 4'd6};
            7'b0001111: res = {1'b0, 4'd7};
            7'b0000000: res = {1'b0, 4'd8};
            7'b0001100: res = {1'b0, 4'd9};
            7'b1111111: res = {1'b0, CODE_BLANK};
`ifdef SEG7_SCAN_ALT_GLYPH_EN
            7'b1100000: res = {1'b0, 4'd6};
            7'b0000100: res = {1'b0, 4'd9};
            7'b0001101: res = {1'b0, 4'd7};
`endif
            default:    res = {1'b1, CODE_ERR};
        endcase
        return res;
    endfunction

    logic [NDIG-1:0] w_dig_act;
    logic            w_dig_onehot;
    logic            w_stable;
    logic            w_capture;
    logic [NDIG-1:0] w_cap_vec;
    logic [4:0]      w_glyph;
    logic [3:0]      w_glyph_code;
    logic            w_glyph_err;
    logic            r_act_done;

    assign w_dig_act    = ~r_dig_s2;
    assign w_dig_onehot = (w_dig_act != '0) && ((w_dig_act & (w_dig_act - NDIG'(1))) == '0);
    assign w_stable     = (r_cnt == CNT_MAX);
    assign w_capture    = w_stable && w_dig_onehot && !r_act_done;
    assign w_cap_vec    = w_capture ? w_dig_act : '0;
    assign w_glyph      = glyph_decode(r_seg_s2);
    assign w_glyph_code = w_glyph[3:0];
    assign w_glyph_err  = w_glyph[4];

    // One capture per activation; a change of the enable pattern starts a new activation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_act_done <= 1'b0;
        end else if (w_dig_change) begin
            r_act_done <= 1'b0;
        end else if (w_capture) begin
            r_act_done <= 1'b1;
        end
    end

    logic [BCD_W-1:0] r_store;
    logic [NDIG-1:0]  r_store_err;
    logic [NDIG-1:0]  r_mask;
    logic             w_frame_done;

    assign w_frame_done = &r_mask;

    // Per-digit stores keep the latest glyph until the frame is handed off.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_store     <= {NDIG{CODE_BLANK}};
            r_store_err <= '0;
            r_mask      <= '0;
        end else begin
            for (int i = 0; i < int'(NDIG); i++) begin
                if (w_cap_vec[i]) begin
                    r_store[4*i +: 4] <= w_glyph_code;
                    r_store_err[i]    <= w_glyph_err;
                end
            end
            r_mask <= (w_frame_done ? '0 : r_mask) | w_cap_vec;
        end
    end

    logic             r_valid;
    logic [BCD_W-1:0] r_bcd;
    logic [NDIG-1:0]  r_err;
    logic             r_overrun;
    logic             w_can_load;

    assign w_can_load = !r_valid || frm.frame_ready;

    // Output holding register; a frame that cannot be loaded is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_bcd     <= '0;
            r_err     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_frame_done && w_can_load) begin
                r_valid <= 1'b1;
                r_bcd   <= r_store;
                r_err   <= r_store_err;
            end else if (r_valid && frm.frame_ready) begin
                r_valid <= 1'b0;
            end
            r_overrun <= (w_frame_done && !w_can_load) || (r_overrun && !clr_overrun);
        end
    end

    assign frm.frame_valid = r_valid;
    assign frm.frame_bcd   = r_bcd;
    assign frm.frame_err   = r_err;
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: vector table, directed corner sequences,
// and a randomized scan checked against an activation-level reference model.
module tb_seg7_scan_decoder;
    localparam int unsigned NDIG       = 4;
    localparam int unsigned STABLE_CYC = 4;

    localparam logic [6:0] GLYPH [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef struct packed {
        logic [4*NDIG-1:0] bcd;
        logic [NDIG-1:0]   err;
    } frame_t;

    typedef struct packed {
        logic [3:0][6:0] glyph;
        logic [15:0]     bcd;
        logic [3:0]      err;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [6:0]      seg_n = '1;
    logic [NDIG-1:0] dig_n = '1;
    logic            overrun;
    logic            clr_overrun = 1'b0;

    int unsigned total = 0;
    int unsigned bad   = 0;

    frame_t rx_q[$];
    frame_t exp_q[$];
    frame_t mon_f;

    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.NDIG(NDIG)) frm_if ();

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .frm         (frm_if),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    // Record every transfer (valid & ready held across the coming rising edge).
    always @(negedge clk) begin
        if (reset_n && frm_if.frame_valid && frm_if.frame_ready) begin
            mon_f.bcd = frm_if.frame_bcd;
            mon_f.err = frm_if.frame_err;
            rx_q.push_back(mon_f);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        if (s == BLANK) return 5'h0F;
        for (int v = 0; v < 10; v++) begin
            if (s == GLYPH[v]) return {1'b0, 4'(v)};
        end
`ifdef SEG7_SCAN_ALT_GLYPH_EN
        if (s == 7'b1100000) return 5'h06;
        if (s == 7'b0000100) return 5'h09;
        if (s == 7'b0001101) return 5'h07;
`endif
        return 5'h1E;
    endfunction

    // Called and returns at posedge + 1; holds the bus for h sampling edges.
    task automatic step(input logic [NDIG-1:0] d, input logic [6:0] s, input int unsigned h);
        dig_n = d;
        seg_n = s;
        repeat (h) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [3:0][6:0] g, input int unsigned h);
        step(4'b1110, g[0], h);
        step(4'b1101, g[1], h);
        step(4'b1011, g[2], h);
        step(4'b0111, g[3], h);
        step(4'b1111, BLANK, h);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        dig_n   = '1;
        seg_n   = BLANK;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        rx_q.delete();
    endtask

    task automatic expect_frame(input string name, input logic [15:0] bcd, input logic [3:0] err,
                                input int unsigned budget);
        int unsigned n;
        frame_t f;
        n = 0;
        while (rx_q.size() == 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (rx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: no frame within %0d cycles, required bcd=%h", name, budget, bcd);
        end else begin
            f = rx_q.pop_front();
            check({name, "_bcd"}, 32'(f.bcd), 32'(bcd));
            check({name, "_err"}, 32'(f.err), 32'(err));
        end
    endtask

    task automatic expect_none(input string name, input int unsigned cycles);
        repeat (cycles) @(posedge clk);
        #1;
        check(name, 32'(rx_q.size()), 32'd0);
    endtask

    vec_t vecs[5];

    // Reference model state (activation level).
    logic [3:0]      m_store [NDIG];
    logic [NDIG-1:0] m_err;
    logic [NDIG-1:0] m_mask;
    logic            m_act;

    initial begin
        int unsigned seen;
        logic [NDIG-1:0] d, prev_d;
        logic [6:0]      s, prev_s;
        int unsigned     h, r, a, b, idx;
        logic [4:0]      dec;
        frame_t          ef, af;

        vecs[0] = '{glyph: {7'b0010010, 7'b1111111, 7'b0001111, 7'b0000110}, bcd: 16'h2F73, err: 4'b0000};
        vecs[1] = '{glyph: {7'b1010101, 7'b1111111, 7'b0001111, 7'b0000110}, bcd: 16'hEF73, err: 4'b1000};
        vecs[2] = '{glyph: {7'b1001100, 7'b0100100, 7'b0001100, 7'b0000000}, bcd: 16'h4598, err: 4'b0000};
        vecs[3] = '{glyph: {7'b1111111, 7'b0100000, 7'b1001111, 7'b0000001}, bcd: 16'hF610, err: 4'b0000};
`ifdef SEG7_SCAN_ALT_GLYPH_EN
        vecs[4] = '{glyph: {7'b0110110, 7'b0001101, 7'b0000100, 7'b1100000}, bcd: 16'hE796, err: 4'b1000};
`else
        vecs[4] = '{glyph: {7'b0110110, 7'b0001101, 7'b0000100, 7'b1100000}, bcd: 16'hEEEE, err: 4'b1111};
`endif

        frm_if.frame_ready = 1'b1;

        // Reset then idle.
        do_reset();
        check("rst_valid", 32'(frm_if.frame_valid), 32'd0);
        check("rst_bcd", 32'(frm_if.frame_bcd), 32'd0);
        check("rst_err", 32'(frm_if.frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (frm_if.frame_valid) seen++;
        end
        check("idle_valid_cycles", seen, 32'd0);
        check("idle_bcd", 32'(frm_if.frame_bcd), 32'd0);
        check("idle_overrun", 32'(overrun), 32'd0);

        // Table-driven clean scans.
        for (int i = 0; i < 5; i++) begin
            scan(vecs[i].glyph, 10);
            expect_frame($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].err, 30);
            check($sformatf("vec%0d_single", i), 32'(rx_q.size()), 32'd0);
        end

        // Glitch: short pattern on digit1 is ignored, the stable one is taken.
        step(4'b1110, 7'b0000110, 10);
        step(4'b1101, GLYPH[8], 3);
        step(4'b1101, 7'b1001111, 10);
        step(4'b1011, BLANK, 10);
        step(4'b0111, 7'b0010010, 10);
        step(4'b1111, BLANK, 10);
        expect_frame("glitch", 16'h2F13, 4'b0000, 30);

        // Two digits enabled at once never capture.
        step(4'b1110, GLYPH[0], 10);
        step(4'b1101, GLYPH[9], 10);
        step(4'b0011, GLYPH[5], 10);
        step(4'b1111, BLANK, 10);
        expect_none("two_dig_no_frame", 20);
        step(4'b1011, GLYPH[5], 10);
        step(4'b0111, GLYPH[4], 10);
        step(4'b1111, BLANK, 10);
        expect_frame("two_dig_after", 16'h4590, 4'b0000, 30);

        // Backpressure and overrun.
        frm_if.frame_ready = 1'b0;
        scan(vecs[0].glyph, 10);
        check("bp_valid1", 32'(frm_if.frame_valid), 32'd1);
        check("bp_bcd1", 32'(frm_if.frame_bcd), 32'h2F73);
        check("bp_ovr1", 32'(overrun), 32'd0);
        scan(vecs[2].glyph, 10);
        check("bp_valid2", 32'(frm_if.frame_valid), 32'd1);
        check("bp_bcd_held", 32'(frm_if.frame_bcd), 32'h2F73);
        check("bp_ovr2", 32'(overrun), 32'd1);
        frm_if.frame_ready = 1'b1;
        clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        frm_if.frame_ready = 1'b0;
        clr_overrun = 1'b0;
        check("bp_valid_after", 32'(frm_if.frame_valid), 32'd0);
        check("bp_ovr_after", 32'(overrun), 32'd0);
        expect_frame("bp_xfer", 16'h2F73, 4'b0000, 5);
        frm_if.frame_ready = 1'b1;

        // Capture latency: digit0 first sampled at edge k, valid must rise at k+6.
        do_reset();
        step(4'b1101, GLYPH[7], 10);
        step(4'b1011, BLANK, 10);
        step(4'b0111, GLYPH[2], 10);
        step(4'b1111, BLANK, 10);
        dig_n = 4'b1110;
        seg_n = GLYPH[3];
        repeat (6) @(posedge clk);
        #1;
        check("lat_k5_not_valid", 32'(frm_if.frame_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_k6_valid", 32'(frm_if.frame_valid), 32'd1);
        step(4'b1111, BLANK, 10);
        expect_frame("lat", 16'h2F73, 4'b0000, 10);

        // Reset mid-scan discards the partial frame.
        step(4'b1110, GLYPH[1], 10);
        step(4'b1101, GLYPH[2], 10);
        step(4'b1011, GLYPH[3], 10);
        do_reset();
        step(4'b0111, GLYPH[4], 10);
        step(4'b1111, BLANK, 10);
        expect_none("rst_mid_no_frame", 20);
        scan(vecs[2].glyph, 10);
        expect_frame("rst_mid_full", 16'h4598, 4'b0000, 30);

        // Randomized scan against the reference model.
        do_reset();
        exp_q.delete();
        for (int i = 0; i < int'(NDIG); i++) m_store[i] = 4'hF;
        m_err  = '0;
        m_mask = '0;
        m_act  = 1'b0;
        prev_d = '1;
        prev_s = BLANK;
        for (int n = 0; n < 250; n++) begin
            do begin
                r = $urandom_range(0, 9);
                if (r < 8) begin
                    d = ~(NDIG'(1) << $urandom_range(0, NDIG - 1));
                end else if (r == 8) begin
                    d = '1;
                end else begin
                    a = $urandom_range(0, 3);
                    b = (a + 1 + $urandom_range(0, 2)) % 4;
                    d = ~((NDIG'(1) << a) | (NDIG'(1) << b));
                end
                r = $urandom_range(0, 9);
                if (r < 7)       s = GLYPH[$urandom_range(0, 9)];
                else if (r == 7) s = BLANK;
                else             s = 7'($urandom);
            end while (d == prev_d && s == prev_s);
            h = $urandom_range(1, 12);

            if (d != prev_d) m_act = 1'b0;
            if ($countones(~d) == 1 && !m_act && h >= STABLE_CYC) begin
                idx = 0;
                for (int j = 0; j < int'(NDIG); j++) if (!d[j]) idx = j;
                dec = ref_decode(s);
                m_store[idx] = dec[3:0];
                m_err[idx]   = dec[4];
                m_mask[idx]  = 1'b1;
                m_act        = 1'b1;
                if (m_mask == '1) begin
                    ef.bcd = {m_store[3], m_store[2], m_store[1], m_store[0]};
                    ef.err = m_err;
                    exp_q.push_back(ef);
                    m_mask = '0;
                end
            end
            step(d, s, h);
            prev_d = d;
            prev_s = s;
        end
        step('1, BLANK, 20);
        check("rand_frame_count", 32'(rx_q.size()), 32'(exp_q.size()));
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            af = rx_q.pop_front();
            ef = exp_q.pop_front();
            check("rand_bcd", 32'(af.bcd), 32'(ef.bcd));
            check("rand_err", 32'(af.err), 32'(ef.err));
        end
        check("rand_overrun", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
